// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit request side and the CDB broadcast side of the
// arbiter; master is the unit/consumer side, slave is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_REQ           = 4,
    parameter int BW_TAG            = 3,
    parameter int BW_PROCESSOR_DATA = 32
);
    logic [NUM_REQ-1:0]                   i_req_valid;
    logic [NUM_REQ-1:0]                   i_req_ready;
    logic [NUM_REQ*BW_TAG-1:0]            i_req_tag_flatten;
    logic [NUM_REQ*BW_PROCESSOR_DATA-1:0] i_req_data_flatten;
    logic                                 i_kill;
    logic                                 o_cdb_valid;
    logic [BW_TAG-1:0]                    o_cdb_tag;
    logic [BW_PROCESSOR_DATA-1:0]         o_cdb_data;
    logic                                 o_err_tag_zero;

    modport master (
        output i_req_valid, i_req_tag_flatten, i_req_data_flatten, i_kill,
        input  i_req_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_err_tag_zero
    );

    modport slave (
        input  i_req_valid, i_req_tag_flatten, i_req_data_flatten, i_kill,
        output i_req_ready, o_cdb_valid, o_cdb_tag, o_cdb_data, o_err_tag_zero
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that grants one functional-unit result per cycle onto
// the registered Common Data Bus; data is carried as two's complement bits.
module cdb_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int BW_TAG            = 3,
    parameter int BW_PROCESSOR_DATA = 32
) (
    input logic          clk,
    input logic          rst_n,
    cdb_arbiter_if.slave bus
);
    localparam int               PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic                         cdb_valid_q, cdb_valid_d;
    logic [BW_TAG-1:0]            cdb_tag_q, cdb_tag_d;
    logic [BW_PROCESSOR_DATA-1:0] cdb_data_q, cdb_data_d;
    logic                         err_tag_zero_q, err_tag_zero_d;

    logic [NUM_REQ-1:0]           grant;
    logic                         granted;
    logic [PTR_W-1:0]             grant_idx;
    logic [BW_TAG-1:0]            grant_tag;
    logic [BW_PROCESSOR_DATA-1:0] grant_data;

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] sel;
        grant      = '0;
        granted    = 1'b0;
        grant_idx  = '0;
        grant_tag  = '0;
        grant_data = '0;
        idx        = 0;
        sel        = '0;
        if (!bus.i_kill) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                sel = PTR_W'(idx);
                if (!granted && bus.i_req_valid[sel]) begin
                    granted    = 1'b1;
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                    grant_tag  = bus.i_req_tag_flatten[sel*BW_TAG +: BW_TAG];
                    grant_data = bus.i_req_data_flatten[sel*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
                end
            end
        end
    end

    always_comb begin
        ptr_d          = ptr_q;
        cdb_valid_d    = 1'b0;
        cdb_tag_d      = '0;
        cdb_data_d     = '0;
        err_tag_zero_d = err_tag_zero_q;
        if (granted) begin
            ptr_d       = (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
            cdb_valid_d = 1'b1;
            cdb_tag_d   = grant_tag;
            cdb_data_d  = grant_data;
            // Tag 0 means "no producer", so accepting it is a protocol error.
            if (grant_tag == '0) begin
                err_tag_zero_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            cdb_valid_q    <= 1'b0;
            cdb_tag_q      <= '0;
            cdb_data_q     <= '0;
            err_tag_zero_q <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            cdb_valid_q    <= cdb_valid_d;
            cdb_tag_q      <= cdb_tag_d;
            cdb_data_q     <= cdb_data_d;
            err_tag_zero_q <= err_tag_zero_d;
        end
    end

    assign bus.i_req_ready    = grant;
    assign bus.o_cdb_valid    = cdb_valid_q;
    assign bus.o_cdb_tag      = cdb_tag_q;
    assign bus.o_cdb_data     = cdb_data_q;
    assign bus.o_err_tag_zero = err_tag_zero_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with literal
// expectations followed by randomized traffic against a round-robin model.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 4;
    localparam int BW_TAG  = 3;
    localparam int BW_DATA = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .BW_TAG(BW_TAG), .BW_PROCESSOR_DATA(BW_DATA)) bus ();

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .BW_TAG(BW_TAG), .BW_PROCESSOR_DATA(BW_DATA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [NUM_REQ-1:0] req_valid;
    logic [BW_TAG-1:0]  req_tag  [NUM_REQ];
    logic [BW_DATA-1:0] req_data [NUM_REQ];
    logic               kill;

    int                 m_ptr;
    logic               m_valid;
    logic [BW_TAG-1:0]  m_tag;
    logic [BW_DATA-1:0] m_data;
    logic               m_err;
    int                 last_winner;
    logic [NUM_REQ-1:0] seen_ready;

    int exp_order [5] = '{0, 1, 2, 3, 0};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        bus.i_req_valid = req_valid;
        bus.i_kill      = kill;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.i_req_tag_flatten[k*BW_TAG +: BW_TAG]    = req_tag[k];
            bus.i_req_data_flatten[k*BW_DATA +: BW_DATA] = req_data[k];
        end
    endtask

    task automatic modelReset();
        m_ptr       = 0;
        m_valid     = 1'b0;
        m_tag       = '0;
        m_data      = '0;
        m_err       = 1'b0;
        last_winner = -1;
    endtask

    // One clock: check ready against the rotating-priority rule, then check
    // the broadcast that the model says must appear after the edge.
    task automatic stepCycle();
        int                 order[$];
        int                 winner;
        logic [NUM_REQ-1:0] exp_ready;
        applyStimulus();
        #1;
        winner    = -1;
        exp_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) order.push_back((m_ptr + k) % NUM_REQ);
        if (!kill) begin
            foreach (order[n]) begin
                if (winner < 0 && req_valid[order[n]]) winner = order[n];
            end
        end
        if (winner >= 0) exp_ready = NUM_REQ'(1) << winner;
        seen_ready = bus.i_req_ready;
        checkOutput("ready", 64'(seen_ready), 64'(exp_ready));
        @(posedge clk);
        if (winner >= 0) begin
            m_valid = 1'b1;
            m_tag   = req_tag[winner];
            m_data  = req_data[winner];
            if (req_tag[winner] == '0) m_err = 1'b1;
            m_ptr = (winner + 1) % NUM_REQ;
        end else begin
            m_valid = 1'b0;
            m_tag   = '0;
            m_data  = '0;
        end
        last_winner = winner;
        #1;
        checkOutput("cdb_valid", 64'(bus.o_cdb_valid), 64'(m_valid));
        checkOutput("cdb_tag", 64'(bus.o_cdb_tag), 64'(m_tag));
        checkOutput("cdb_data", 64'(bus.o_cdb_data), 64'(m_data));
        checkOutput("err_tag_zero", 64'(bus.o_err_tag_zero), 64'(m_err));
    endtask

    // Reset is asserted between clock edges so the clear must be asynchronous.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_cdb_valid", 64'(bus.o_cdb_valid), 64'd0);
        checkOutput("rst_cdb_tag", 64'(bus.o_cdb_tag), 64'd0);
        checkOutput("rst_cdb_data", 64'(bus.o_cdb_data), 64'd0);
        checkOutput("rst_err", 64'(bus.o_err_tag_zero), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_valid = '0;
        kill      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_tag[k]  = '0;
            req_data[k] = '0;
        end
        applyStimulus();
        @(posedge clk);
        #1;
        doReset();

        repeat (3) stepCycle();

        req_tag[2]  = 3'd5;
        req_data[2] = 32'hFFFF_FFF9;
        req_valid   = 4'b0100;
        stepCycle();
        checkOutput("u2_ready", 64'(seen_ready), 64'b0100);
        checkOutput("u2_tag", 64'(bus.o_cdb_tag), 64'd5);
        checkOutput("u2_data", 64'(bus.o_cdb_data), 64'hFFFF_FFF9);
        checkOutput("u2_ptr_model", 64'(m_ptr), 64'd3);

        req_tag[1]  = 3'd6;
        req_data[1] = 32'h0000_1234;
        req_tag[3]  = 3'd7;
        req_data[3] = 32'h8000_0001;
        req_valid   = 4'b1010;
        stepCycle();
        checkOutput("wrap_first_ready", 64'(seen_ready), 64'b1000);
        checkOutput("wrap_first_tag", 64'(bus.o_cdb_tag), 64'd7);
        req_valid[3] = 1'b0;
        stepCycle();
        checkOutput("wrap_second_ready", 64'(seen_ready), 64'b0010);
        checkOutput("wrap_second_tag", 64'(bus.o_cdb_tag), 64'd6);
        checkOutput("wrap_ptr_model", 64'(m_ptr), 64'd2);
        req_valid = '0;

        doReset();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_tag[k]  = BW_TAG'(k + 1);
            req_data[k] = 32'h100 * (k + 1);
        end
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("order_winner", 64'(last_winner), 64'(exp_order[i]));
            checkOutput("order_tag", 64'(bus.o_cdb_tag), 64'(exp_order[i] + 1));
            checkOutput("order_no_bubble", 64'(bus.o_cdb_valid), 64'd1);
        end

        kill = 1'b1;
        repeat (2) stepCycle();
        checkOutput("kill_ready", 64'(seen_ready), 64'd0);
        checkOutput("kill_cdb_valid", 64'(bus.o_cdb_valid), 64'd0);
        checkOutput("kill_ptr_model", 64'(m_ptr), 64'd1);
        kill = 1'b0;
        stepCycle();
        checkOutput("resume_ready", 64'(seen_ready), 64'b0010);

        req_tag[0]  = '0;
        req_data[0] = 32'hDEAD_BEEF;
        req_valid   = 4'b0001;
        stepCycle();
        checkOutput("tag0_cdb_valid", 64'(bus.o_cdb_valid), 64'd1);
        checkOutput("tag0_err", 64'(bus.o_err_tag_zero), 64'd1);
        req_valid = '0;
        repeat (2) stepCycle();
        checkOutput("tag0_err_sticky", 64'(bus.o_err_tag_zero), 64'd1);
        req_tag[0] = 3'd1;
        req_valid  = 4'b1111;
        stepCycle();
        doReset();

        // Requesters hold until handshake, may be flushed while killed, and
        // occasionally present tag 0.
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            if (last_winner >= 0) req_valid[last_winner] = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && kill && $urandom_range(0, 4) == 0) begin
                    req_valid[k] = 1'b0;
                end else if (!req_valid[k] && $urandom_range(0, 9) < 4) begin
                    req_valid[k] = 1'b1;
                    req_tag[k]   = ($urandom_range(0, 15) == 0) ? '0 : BW_TAG'($urandom_range(1, 7));
                    req_data[k]  = $urandom;
                end
            end
            kill = ($urandom_range(0, 7) == 0);
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
